serial_arith_unit: RTL and testbench

//  Parametrised bit-serial arithmetic unit: the accumulator/multiplier datapath of the computer subsystem.

---
 rtl/serial_arith_unit.sv | 186 ++++++++++++++++++
 tb/tb_serial_arith_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_arith_unit.sv
// Bit-serial accumulator/multiplier datapath: executes A/S/C/H/T/U/R/L/E/G
// orders on LSB-first words framed by d0, under a start/busy/done handshake.
//
// Ports:
//   clk, rst  digit clock, async active-high reset
//   d0        digit pulse marking bit 0 of the word on mib
//   start/op/shamt  order request, code and shift count (sampled on accept)
//   mib/mob   serial operand in / serial accumulator out (T/U only)
//   busy/done/err   handshake status; err pulses with done on illegal op
//   dv_d      jump condition for E/G, valid with done
//   acc_neg   live accumulator sign, ovf sticky signed overflow
module serial_arith_unit #(
  parameter int WORD_BITS = 36,
  parameter int SHAMT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d0,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               mib,
  output logic               mob,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               dv_d,
  output logic               acc_neg,
  output logic               ovf
);

  localparam int BC_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  localparam logic [3:0] OP_A = 4'd0;
  localparam logic [3:0] OP_S = 4'd1;
  localparam logic [3:0] OP_C = 4'd2;
  localparam logic [3:0] OP_H = 4'd3;
  localparam logic [3:0] OP_T = 4'd4;
  localparam logic [3:0] OP_U = 4'd5;
  localparam logic [3:0] OP_R = 4'd6;
  localparam logic [3:0] OP_L = 4'd7;
  localparam logic [3:0] OP_E = 4'd8;
  localparam logic [3:0] OP_G = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_D0,
    SERIAL,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WORD_BITS-1:0] acc;
  logic [WORD_BITS-1:0] mplier;
  logic [3:0]           op_q;
  logic [SHAMT_W-1:0]   sh_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic                 carry;
  logic                 mib_q;
  logic                 dv_q;
  logic                 err_q;

  logic accept;
  logic in_serial;
  logic in_shift;
  logic last_bit;
  logic a_bit;
  logic b_bit;
  logic sum_bit;
  logic cout_bit;
  logic is_add;
  logic is_xfer;

  // New orders are taken in IDLE and also in DONE for back-to-back issue.
  assign accept    = start && (state == IDLE || state == DONE);
  assign in_serial = (op <= OP_U);
  assign in_shift  = (op == OP_R) || (op == OP_L);
  assign last_bit  = (bit_cnt == BC_W'(WORD_BITS - 1));

  assign is_add  = (op_q == OP_A) || (op_q == OP_S) || (op_q == OP_C);
  assign is_xfer = (op_q == OP_T) || (op_q == OP_U);

  // mib is registered so that bit 0, present in the d0 cycle, is
  // consumed in the first SERIAL cycle.
  assign a_bit = acc[bit_cnt];

  always_comb begin
    b_bit = mib_q;
    unique case (1'b1)
      op_q == OP_S: b_bit = ~mib_q;
      op_q == OP_C: b_bit = mib_q & mplier[bit_cnt];
      default:      b_bit = mib_q;
    endcase
  end

  assign sum_bit  = a_bit ^ b_bit ^ carry;
  assign cout_bit = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nx = IDLE;
        if (start) begin
          unique case (1'b1)
            in_serial: state_nx = WAIT_D0;
            in_shift:  state_nx = (shamt == '0) ? DONE : SHIFT;
            default:   state_nx = DONE;
          endcase
        end
      end
      WAIT_D0: if (d0) state_nx = SERIAL;
      SERIAL:  if (last_bit) state_nx = DONE;
      SHIFT:   if (sh_cnt == SHAMT_W'(1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mplier  <= '0;
      op_q    <= '0;
      sh_cnt  <= '0;
      bit_cnt <= '0;
      carry   <= 1'b0;
      mib_q   <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      mib_q <= mib;
      if (accept) begin
        op_q    <= op;
        sh_cnt  <= shamt;
        bit_cnt <= '0;
        carry   <= (op == OP_S);
        err_q   <= (op > OP_G);
        dv_q    <= 1'b0;
        if (op == OP_E) dv_q <= ~acc[WORD_BITS-1];
        if (op == OP_G) dv_q <= acc[WORD_BITS-1];
      end
      unique case (state)
        SERIAL: begin
          bit_cnt <= bit_cnt + BC_W'(1);
          if (is_add) begin
            acc[bit_cnt] <= sum_bit;
            carry        <= cout_bit;
            // Carry into the sign differs from carry out: signed overflow.
            if (last_bit && (carry != cout_bit)) ovf <= 1'b1;
          end
          if (op_q == OP_H) mplier[bit_cnt] <= mib_q;
          if (op_q == OP_T && last_bit) begin
            acc <= '0;
            ovf <= 1'b0;
          end
        end
        SHIFT: begin
          sh_cnt <= sh_cnt - SHAMT_W'(1);
          if (op_q == OP_R) begin
            acc <= {acc[WORD_BITS-1], acc[WORD_BITS-1:1]};
          end else begin
            acc <= {acc[WORD_BITS-2:0], 1'b0};
            if (acc[WORD_BITS-1] != acc[WORD_BITS-2]) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == WAIT_D0) || (state == SERIAL) || (state == SHIFT);
  assign done    = (state == DONE);
  assign err     = (state == DONE) && err_q;
  assign dv_d    = (state == DONE) && dv_q;
  assign mob     = (state == SERIAL) && is_xfer && a_bit;
  assign acc_neg = acc[WORD_BITS-1];

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed bench for serial_arith_unit (WORD_BITS=8, SHAMT_W=3).
// The accumulator is observed by streaming it out with U orders.
module tb_serial_arith_unit;

  localparam logic [3:0] A = 4'd0, S = 4'd1, C = 4'd2, H = 4'd3;
  localparam logic [3:0] T = 4'd4, U = 4'd5, R = 4'd6, L = 4'd7;
  localparam logic [3:0] E = 4'd8, G = 4'd9;

  logic       clk = 0;
  logic       rst = 1;
  logic       d0 = 0;
  logic       start = 0;
  logic [3:0] op = 0;
  logic [2:0] shamt = 0;
  logic       mib = 0;
  logic       mob, busy, done, err, dv_d, acc_neg, ovf;

  int n_chk = 0;
  int n_fail = 0;

  serial_arith_unit #(.WORD_BITS(8), .SHAMT_W(3)) dut (
    .clk(clk), .rst(rst), .d0(d0), .start(start), .op(op),
    .shamt(shamt), .mib(mib), .mob(mob), .busy(busy), .done(done),
    .err(err), .dv_d(dv_d), .acc_neg(acc_neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues a serial order; d0 comes in the first cycle after acceptance.
  // ok reports: busy after accept, no early done, done exactly 9 cycles
  // after d0 with busy low, and done lasting one cycle.
  task automatic serial_order(input logic [3:0] o, input logic [7:0] w,
                              input int glitch, input int hold,
                              output logic [7:0] mw, output logic ok);
    logic [7:0] wt;
    ok = 1'b1;
    mw = '0;
    op = o;
    start = 1'b1;
    tick;
    if (!busy) ok = 1'b0;
    if (hold == 0) start = 1'b0;
    d0 = 1'b1;
    mib = w[0];
    tick;
    d0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mw[i] = mob;
      if (done) ok = 1'b0;
      if (i + 1 >= hold) start = 1'b0;
      wt = w >> (i + 1);
      mib = wt[0];
      d0 = (i == glitch);
      tick;
    end
    start = 1'b0;
    d0 = 1'b0;
    if (!(done && !busy)) ok = 1'b0;
    tick;
    if (done) ok = 1'b0;
  endtask

  task automatic short_order(input logic [3:0] o, input logic [2:0] sh,
                             output int cyc, output logic dvv,
                             output logic errv);
    op = o;
    shamt = sh;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      tick;
      cyc++;
    end
    dvv = dv_d;
    errv = err;
    tick;
  endtask

  task automatic read_acc(output logic [7:0] v);
    logic ok;
    serial_order(U, 8'h00, -1, 0, v, ok);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    #2;
    n_chk++;
    if ({mob, busy, done, err, dv_d, acc_neg, ovf} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0",
               {mob, busy, done, err, dv_d, acc_neg, ovf});
    end
    tick;
    rst = 1'b0;
    tick;
    read_acc(v);
    n_chk++;
    if (v !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_acc: got %h expected 00", v);
    end
  endtask

  task automatic test_add;
    logic [7:0] v;
    logic ok;
    serial_order(A, 8'h05, -1, 0, v, ok);
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL add1_timing: got %b expected 1", ok);
    end
    serial_order(A, 8'h03, -1, 0, v, ok);
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL add2_timing: got %b expected 1", ok);
    end
    read_acc(v);
    n_chk++;
    if (v !== 8'h08) begin
      n_fail++;
      $display("FAIL add_acc: got %h expected 08", v);
    end
    n_chk++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ovf: got %b expected 0", ovf);
    end
  endtask

  task automatic test_overflow_transfer;
    logic [7:0] v;
    logic ok;
    serial_order(T, 8'h00, -1, 0, v, ok);
    n_chk++;
    if (v !== 8'h08) begin
      n_fail++;
      $display("FAIL t_mob_08: got %h expected 08", v);
    end
    serial_order(A, 8'h7F, -1, 0, v, ok);
    serial_order(A, 8'h01, -1, 0, v, ok);
    n_chk++;
    if ({ovf, acc_neg} !== 2'b11) begin
      n_fail++;
      $display("FAIL ovf_neg: got %b expected 11", {ovf, acc_neg});
    end
    serial_order(T, 8'h00, -1, 0, v, ok);
    n_chk++;
    if (v !== 8'h80 || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL t_mob_80: got %h/%b expected 80/1", v, ok);
    end
    n_chk++;
    if ({ovf, acc_neg} !== 2'b00) begin
      n_fail++;
      $display("FAIL t_clear_flags: got %b expected 00", {ovf, acc_neg});
    end
    read_acc(v);
    n_chk++;
    if (v !== 8'h00) begin
      n_fail++;
      $display("FAIL t_clear_acc: got %h expected 00", v);
    end
  endtask

  task automatic test_multiply;
    logic [7:0] v;
    logic ok;
    serial_order(H, 8'h0F, -1, 0, v, ok);
    read_acc(v);
    n_chk++;
    if (v !== 8'h00) begin
      n_fail++;
      $display("FAIL h_acc: got %h expected 00", v);
    end
    serial_order(C, 8'h3C, -1, 0, v, ok);
    read_acc(v);
    n_chk++;
    if (v !== 8'h0C) begin
      n_fail++;
      $display("FAIL c_acc: got %h expected 0c", v);
    end
    serial_order(S, 8'h0C, -1, 0, v, ok);
    read_acc(v);
    n_chk++;
    if (v !== 8'h00 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL s_acc: got %h/%b expected 00/0", v, ovf);
    end
  endtask

  task automatic test_shift;
    logic [7:0] v;
    logic ok, dv, e;
    int cyc;
    serial_order(A, 8'hF0, -1, 0, v, ok);
    short_order(R, 3'd2, cyc, dv, e);
    read_acc(v);
    n_chk++;
    if (v !== 8'hFC || cyc != 3) begin
      n_fail++;
      $display("FAIL r2: got %h cyc %0d expected fc cyc 3", v, cyc);
    end
    short_order(L, 3'd3, cyc, dv, e);
    read_acc(v);
    n_chk++;
    if (v !== 8'hE0 || cyc != 4 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL l3: got %h cyc %0d ovf %b expected e0 cyc 4 ovf 0",
               v, cyc, ovf);
    end
    serial_order(T, 8'h00, -1, 0, v, ok);
    serial_order(A, 8'h40, -1, 0, v, ok);
    short_order(L, 3'd1, cyc, dv, e);
    read_acc(v);
    n_chk++;
    if (v !== 8'h80 || cyc != 2 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL l1_ovf: got %h cyc %0d ovf %b expected 80 cyc 2 ovf 1",
               v, cyc, ovf);
    end
    short_order(R, 3'd0, cyc, dv, e);
    read_acc(v);
    n_chk++;
    if (v !== 8'h80 || cyc != 1) begin
      n_fail++;
      $display("FAIL r0: got %h cyc %0d expected 80 cyc 1", v, cyc);
    end
  endtask

  task automatic test_jump_illegal;
    logic [7:0] v;
    logic dv, e;
    int cyc;
    short_order(G, 3'd0, cyc, dv, e);
    n_chk++;
    if ({dv, e} !== 2'b10 || cyc != 1) begin
      n_fail++;
      $display("FAIL g_neg: got dv/err %b cyc %0d expected 10 cyc 1",
               {dv, e}, cyc);
    end
    short_order(E, 3'd0, cyc, dv, e);
    n_chk++;
    if ({dv, e} !== 2'b00 || cyc != 1) begin
      n_fail++;
      $display("FAIL e_neg: got dv/err %b cyc %0d expected 00 cyc 1",
               {dv, e}, cyc);
    end
    short_order(4'd12, 3'd0, cyc, dv, e);
    n_chk++;
    if ({dv, e} !== 2'b01 || cyc != 1) begin
      n_fail++;
      $display("FAIL illegal: got dv/err %b cyc %0d expected 01 cyc 1",
               {dv, e}, cyc);
    end
    read_acc(v);
    n_chk++;
    if (v !== 8'h80) begin
      n_fail++;
      $display("FAIL illegal_acc: got %h expected 80", v);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    logic [3:0] obs;
    op = R;
    shamt = 3'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    obs[0] = done;
    op = L;
    start = 1'b1;
    tick;
    obs[1] = busy;
    obs[2] = ~done;
    start = 1'b0;
    tick;
    obs[3] = done;
    tick;
    n_chk++;
    if (obs !== 4'hF) begin
      n_fail++;
      $display("FAIL b2b_handshake: got %b expected 1111", obs);
    end
    read_acc(v);
    n_chk++;
    if (v !== 8'h80 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_acc: got %h/%b expected 80/1", v, ovf);
    end
  endtask

  task automatic test_reset_abort;
    logic [7:0] v;
    int seen = 0;
    op = A;
    start = 1'b1;
    tick;
    start = 1'b0;
    d0 = 1'b1;
    mib = 1'b1;
    tick;
    d0 = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({mob, busy, done, err, dv_d, acc_neg, ovf} !== 7'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected 0",
               {mob, busy, done, err, dv_d, acc_neg, ovf});
    end
    tick;
    rst = 1'b0;
    mib = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      tick;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done cycles expected 0", seen);
    end
    read_acc(v);
    n_chk++;
    if (v !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_acc: got %h expected 00", v);
    end
  endtask

  task automatic test_hold_glitch;
    logic [7:0] v;
    logic ok;
    serial_order(A, 8'h25, 3, 5, v, ok);
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_glitch_timing: got %b expected 1", ok);
    end
    read_acc(v);
    n_chk++;
    if (v !== 8'h25) begin
      n_fail++;
      $display("FAIL hold_glitch_acc: got %h expected 25", v);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_overflow_transfer;
    test_multiply;
    test_shift;
    test_jump_illegal;
    test_back_to_back;
    test_reset_abort;
    test_hold_glitch;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
